// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// Module : imm_pkg
// Brief  : Shared constants for the RV32I immediate encoder (selects, masks,
//          signed field widths, error flag bundle, representability helper).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_pkg;

  localparam int IMM_W = 32;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] IMM_I = 3'b000;
  localparam logic [SEL_W-1:0] IMM_S = 3'b001;
  localparam logic [SEL_W-1:0] IMM_B = 3'b010;
  localparam logic [SEL_W-1:0] IMM_U = 3'b011;
  localparam logic [SEL_W-1:0] IMM_J = 3'b100;

  localparam logic [IMM_W-1:0] MASK_I = 32'hFFF0_0000;
  localparam logic [IMM_W-1:0] MASK_S = 32'hFE00_0F80;
  localparam logic [IMM_W-1:0] MASK_B = 32'hFE00_0F80;
  localparam logic [IMM_W-1:0] MASK_U = 32'hFFFF_F000;
  localparam logic [IMM_W-1:0] MASK_J = 32'hFFFF_F000;

  localparam int SW_I = 12;
  localparam int SW_S = 12;
  localparam int SW_B = 13;
  localparam int SW_J = 21;

  typedef struct packed {
    logic e_range;
    logic e_align;
    logic e_sel;
  } imm_err_t;

  // True when v equals the sign extension of its low w bits.
  function automatic logic fits_signed(input logic [IMM_W-1:0] v, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < IMM_W; i++) begin
      if (i >= w - 1 && v[i] != v[IMM_W-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
//------------------------------------------------------------------------------
// Module : imm_pack
// Brief  : Combinational scatter of an immediate into an instruction word, with
//          range/alignment checks when IMMENC_RANGE_CHECK_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_pack
  import imm_pkg::*;
(
  input  logic [IMM_W-1:0] imm,
  input  logic [SEL_W-1:0] imm_sel,
  input  logic [IMM_W-1:0] base_instr,
  output logic [IMM_W-1:0] word,
  output imm_err_t         err
);

  logic [IMM_W-1:0] scatter;
  logic [IMM_W-1:0] mask;

  always_comb begin
    scatter = '0;
    mask    = '0;
    err     = '0;
    case (imm_sel)
      IMM_I: begin
        scatter = {imm[11:0], 20'b0};
        mask    = MASK_I;
`ifdef IMMENC_RANGE_CHECK_EN
        err.e_range = !fits_signed(imm, SW_I);
`endif
      end
      IMM_S: begin
        scatter = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        mask    = MASK_S;
`ifdef IMMENC_RANGE_CHECK_EN
        err.e_range = !fits_signed(imm, SW_S);
`endif
      end
      IMM_B: begin
        scatter = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        mask    = MASK_B;
`ifdef IMMENC_RANGE_CHECK_EN
        err.e_range = !fits_signed(imm, SW_B);
        err.e_align = imm[0];
`endif
      end
      IMM_U: begin
        scatter = {imm[31:12], 12'b0};
        mask    = MASK_U;
`ifdef IMMENC_RANGE_CHECK_EN
        err.e_range = |imm[11:0];
`endif
      end
      IMM_J: begin
        scatter = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        mask    = MASK_J;
`ifdef IMMENC_RANGE_CHECK_EN
        err.e_range = !fits_signed(imm, SW_J);
        err.e_align = imm[0];
`endif
      end
      // Illegal selects pass the base word through untouched.
      default: err.e_sel = 1'b1;
    endcase
    word = (base_instr & ~mask) | (scatter & mask);
  end

endmodule

`default_nettype wire

// File: rtl/imm_encode.sv
//------------------------------------------------------------------------------
// Module : imm_encode
// Brief  : Two-stage valid/ready RV32I immediate encoder with error counting.
//          Range/alignment checking enabled by defining IMMENC_RANGE_CHECK_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_encode
  import imm_pkg::*;
#(
  parameter int K  = 3,
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  imm,
  input  logic [K-1:0]  imm_sel,
  input  logic [N-1:0]  base_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  instr_out,
  output logic          err_range,
  output logic          err_align,
  output logic          err_sel,
  output logic [CW-1:0] err_count
);

  logic          a_valid_q, a_valid_d;
  logic [N-1:0]  a_imm_q, a_imm_d;
  logic [K-1:0]  a_sel_q, a_sel_d;
  logic [N-1:0]  a_base_q, a_base_d;
  logic          b_valid_q, b_valid_d;
  logic [N-1:0]  b_instr_q, b_instr_d;
  imm_err_t      b_err_q, b_err_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic          a_ready;
  logic          accept;
  logic          consume;
  logic [N-1:0]  pack_word;
  imm_err_t      pack_err;

  imm_pack u_pack (
    .imm        (a_imm_q),
    .imm_sel    (a_sel_q),
    .base_instr (a_base_q),
    .word       (pack_word),
    .err        (pack_err)
  );

  always_comb begin
    a_ready  = !b_valid_q || out_ready;
    in_ready = (!a_valid_q || a_ready) && rst_n;
    accept   = in_valid && in_ready;
    consume  = b_valid_q && out_ready;

    a_valid_d   = a_valid_q;
    a_imm_d     = a_imm_q;
    a_sel_d     = a_sel_q;
    a_base_d    = a_base_q;
    b_valid_d   = b_valid_q;
    b_instr_d   = b_instr_q;
    b_err_d     = b_err_q;
    err_count_d = err_count_q;

    if (accept) begin
      a_valid_d = 1'b1;
      a_imm_d   = imm;
      a_sel_d   = imm_sel;
      a_base_d  = base_instr;
    end else if (a_ready) begin
      a_valid_d = 1'b0;
    end

    // Stage B only advances when its current result is gone or leaving now.
    if (a_ready) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_instr_d = pack_word;
        b_err_d   = pack_err;
      end
    end

    if (consume && (|b_err_q) && (err_count_q != {CW{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_imm_q     <= '0;
      a_sel_q     <= '0;
      a_base_q    <= '0;
      b_valid_q   <= 1'b0;
      b_instr_q   <= '0;
      b_err_q     <= '0;
      err_count_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_imm_q     <= a_imm_d;
      a_sel_q     <= a_sel_d;
      a_base_q    <= a_base_d;
      b_valid_q   <= b_valid_d;
      b_instr_q   <= b_instr_d;
      b_err_q     <= b_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = b_valid_q;
  assign instr_out = b_instr_q;
  assign err_range = b_err_q.e_range;
  assign err_align = b_err_q.e_align;
  assign err_sel   = b_err_q.e_sel;
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encode.sv
//------------------------------------------------------------------------------
// Module : tb_imm_encode
// Brief  : Scoreboard bench for imm_encode; reference model built from per-bit
//          field mapping and signed-range arithmetic.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [2:0]  imm_sel;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic        err_range;
  logic        err_align;
  logic        err_sel;
  logic [15:0] err_count;

  imm_encode #(.K(3), .N(32), .CW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm        (imm),
    .imm_sel    (imm_sel),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .err_range  (err_range),
    .err_align  (err_align),
    .err_sel    (err_sel),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  f;   // {range, align, sel}
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          cnt_model = 0;
  int          ready_mode = 2;   // 0 random, 1 always, 2 never
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate bit that lands in instruction bit p, or -1 when p is not an imm bit.
  function automatic int src_bit(input logic [2:0] s, input int p);
    case (s)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: if (p >= 25) return p - 20; else if (p >= 7 && p <= 11) return p - 7; else return -1;
      3'd2: if (p == 31) return 12; else if (p >= 25) return p - 20;
            else if (p >= 8 && p <= 11) return p - 7; else if (p == 7) return 11; else return -1;
      3'd3: return (p >= 12) ? p : -1;
      3'd4: if (p == 31) return 20; else if (p >= 21) return p - 20;
            else if (p == 20) return 11; else if (p >= 12) return p; else return -1;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [31:0] i, input logic [2:0] s, input logic [31:0] b);
    exp_t e;
    e.w = b;
    e.f = 3'b000;
    if (s > 3'd4) begin
      e.f[0] = 1'b1;
      return e;
    end
    for (int p = 0; p < 32; p++) begin
      int k;
      k = src_bit(s, p);
      if (k >= 0) e.w[p] = i[k];
    end
`ifdef IMMENC_RANGE_CHECK_EN
    begin
      longint v;
      v = longint'($signed(i));
      case (s)
        3'd0, 3'd1: e.f[2] = (v < -2048) || (v > 2047);
        3'd2:       e.f[2] = (v < -4096) || (v > 4095);
        3'd3:       e.f[2] = (i % 4096) != 0;
        default:    e.f[2] = (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1);
      endcase
      e.f[1] = (s == 3'd2 || s == 3'd4) && (i % 2 == 1);
    end
`endif
    return e;
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready, 0);
      sb_q.delete();
      cnt_model  = 0;
      prev_stall = 1'b0;
    end else begin
      logic [34:0] cur;
      cur = {err_range, err_align, err_sel, instr_out};
      chk("err_count", err_count, cnt_model);
      chk("in_ready", in_ready, (sb_q.size() < 2) || out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_stable", cur, prev_out);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", cur, {e.f, e.w});
          if (e.f != 3'b000 && cnt_model < 65535) cnt_model++;
        end
      end else if (out_valid && sb_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end
      if (in_valid && in_ready) sb_q.push_back(ref_model(imm, imm_sel, base_instr));
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [31:0] b);
    int  n;
    bit  acc;
    n   = 0;
    acc = 0;
    imm = i; imm_sel = s; base_instr = b; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic signed [31:0] t;
    int w;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       w = 12;
      2:       w = 13;
      default: w = 21;
    endcase
    t = $signed($urandom << (32 - w));
    t = t >>> (32 - w);
    if ($urandom_range(0, 1) == 1) t[0] = 1'b0;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; imm = '0; imm_sel = '0; base_instr = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_flags", {err_range, err_align, err_sel}, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;

    // Latency: captured at the accepting edge, visible after the following edge.
    send(32'hFFFF_F800, 3'b000, 32'h0000_0013);
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_word", instr_out, 32'h8000_0013);

    send(32'h0000_0010, 3'b010, 32'h0000_0063);
    send(32'h0000_0003, 3'b100, 32'h0000_006F);
    send(32'h1234_5000, 3'b011, 32'h0000_0037);
    send(32'h0000_0800, 3'b000, 32'h0000_0013);
    send(32'hFFFF_FFFF, 3'b001, 32'h0000_0023);
    send(32'h0000_0FFF, 3'b010, 32'h0000_0063);
    send(32'h0000_0001, 3'b011, 32'h0000_0037);
    send(32'h000F_FFFE, 3'b100, 32'h0000_006F);
    send(32'h0010_0000, 3'b100, 32'h0000_006F);
    send(32'h1234_5678, 3'b111, 32'hDEAD_BEEF);
    send(32'h0000_0000, 3'b101, 32'h0000_0013);
    drain();

    // Backpressure: two fill the pipe, the third waits.
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'h0000_0004, 3'b000, 32'h0000_0013);
    send(32'h0000_0008, 3'b001, 32'h0000_0023);
    imm = 32'h0000_000C; imm_sel = 3'b011; base_instr = 32'h0000_0037; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    ready_mode = 1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_stream0", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_stream", out_valid, 1);
    end
    drain();

    // Randomized traffic with random backpressure.
    ready_mode = 0;
    for (int t = 0; t < 300; t++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      send(rand_imm(), s, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // Reset with two in flight.
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'h0000_0003, 3'b100, 32'h0000_006F);
    send(32'h0000_0000, 3'b110, 32'h1111_1111);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_err_count", err_count, 0);
    chk("rst2_instr_out", instr_out, 0);
    chk("rst2_in_ready", in_ready, 0);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (4) begin
      @(negedge clk);
      chk("rst2_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
